// File: rtl/kmean_mem_pkg.sv
// Shared types and constants for the K-means sample replay memory.
package kmean_mem_pkg;

  localparam int unsigned KM_DATA_W_DEF = 16;
  localparam int unsigned KM_DEPTH_DEF  = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_REPLAY
  } km_state_e;

  // Address width needed to index 'depth' entries (ceil(log2(depth))).
  function automatic int unsigned km_addr_w(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/kmean_sram_sp.sv
// Single-port synchronous RAM: synchronous write, registered one-cycle read,
// array is not reset.
module kmean_sram_sp
  import kmean_mem_pkg::*;
#(
  parameter int unsigned DATA_W = KM_DATA_W_DEF,
  parameter int unsigned DEPTH  = KM_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          i_we,
  input  logic [km_addr_w(DEPTH)-1:0]   i_addr,
  input  logic [DATA_W-1:0]             i_wdata,
  output logic [DATA_W-1:0]             o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/kmean_replay_mem.sv
// Burst-capture sample store that replays its contents forward or reverse
// on request, with output back-pressure and sticky overflow reporting.
module kmean_replay_mem
  import kmean_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = KM_DATA_W_DEF,
  parameter int unsigned DEPTH       = KM_DEPTH_DEF,
  parameter bit          AUTO_REPLAY = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        rd_start,
  input  logic                        rd_reverse,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic [km_addr_w(DEPTH):0]   count,
  output logic                        busy,
  output logic                        overflow
);

  localparam int unsigned AW = km_addr_w(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  km_state_e         r_state, w_next;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_busy;
  logic              r_rev;
  logic [AW-1:0]     r_addr;
  logic [CW-1:0]     r_left;
  logic              r_rvalid;
  logic              r_rlast;
  logic [DATA_W-1:0] r_q0, r_q1;
  logic              r_l0, r_l1;
  logic [1:0]        r_n;

  logic              w_start_load;
  logic              w_load_word;
  logic              w_we;
  logic              w_pop;
  logic              w_last_pop;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic [AW-1:0]     w_ram_addr;
  logic [DATA_W-1:0] w_rdata;

  assign w_start_load = ((r_state == ST_IDLE) || (r_state == ST_READY)) && in_valid;
  assign w_load_word  = (r_state == ST_LOAD) && in_valid && (r_count != FULL);
  assign w_we         = w_start_load | w_load_word;
  assign w_pop        = (r_n != 2'd0) && out_ready;
  assign w_last_pop   = w_pop && r_l0;
  // A read may be issued only if its data is guaranteed a skid slot when it
  // lands next cycle, assuming the consumer stalls from now on.
  assign w_occ        = {1'b0, r_n} + {2'b00, r_rvalid} - {2'b00, w_pop};
  assign w_issue      = (r_state == ST_REPLAY) && (r_left != '0) && (w_occ <= 3'd1);
  assign w_ram_addr   = (r_state == ST_REPLAY) ? r_addr :
                        (r_state == ST_LOAD)   ? r_count[AW-1:0] : '0;

  kmean_sram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_ram_addr),
    .i_wdata (in_data),
    .o_rdata (w_rdata)
  );

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_next = ST_LOAD;
      ST_LOAD:   if (!in_valid) w_next = (AUTO_REPLAY && (r_count != '0)) ? ST_REPLAY : ST_READY;
      ST_READY: begin
        if (in_valid)                          w_next = ST_LOAD;
        else if (rd_start && (r_count != '0))  w_next = ST_REPLAY;
      end
      ST_REPLAY: if (w_last_pop) w_next = ST_READY;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State register, busy flag, sample count and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_LOAD) || (w_next == ST_REPLAY);
      if (w_start_load) begin
        r_count    <= CW'(1);
        r_overflow <= 1'b0;
      end else if ((r_state == ST_LOAD) && in_valid) begin
        if (r_count != FULL) r_count    <= r_count + CW'(1);
        else                 r_overflow <= 1'b1;
      end else if ((r_state == ST_REPLAY) && in_valid) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Replay read sequencer: sets up direction on entry, then walks addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rev    <= 1'b0;
      r_addr   <= '0;
      r_left   <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else begin
      if ((r_state != ST_REPLAY) && (w_next == ST_REPLAY)) begin
        r_rev  <= (r_state == ST_READY) && rd_reverse;
        r_addr <= ((r_state == ST_READY) && rd_reverse) ? (r_count[AW-1:0] - AW'(1)) : '0;
        r_left <= r_count;
      end else if (w_issue) begin
        r_addr <= r_rev ? (r_addr - AW'(1)) : (r_addr + AW'(1));
        r_left <= r_left - CW'(1);
      end
      r_rvalid <= w_issue;
      r_rlast  <= w_issue && (r_left == CW'(1));
    end
  end

  // Two-entry output skid buffer; entry 0 is the word presented downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n  <= 2'd0;
      r_q0 <= '0;
      r_q1 <= '0;
      r_l0 <= 1'b0;
      r_l1 <= 1'b0;
    end else begin
      case ({r_rvalid, w_pop})
        2'b10: begin
          if (r_n == 2'd0) begin
            r_q0 <= w_rdata;
            r_l0 <= r_rlast;
          end else begin
            r_q1 <= w_rdata;
            r_l1 <= r_rlast;
          end
          r_n <= r_n + 2'd1;
        end
        2'b01: begin
          r_q0 <= r_q1;
          r_l0 <= r_l1;
          r_n  <= r_n - 2'd1;
        end
        2'b11: begin
          if (r_n == 2'd1) begin
            r_q0 <= w_rdata;
            r_l0 <= r_rlast;
          end else begin
            r_q0 <= r_q1;
            r_l0 <= r_l1;
            r_q1 <= w_rdata;
            r_l1 <= r_rlast;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (r_n != 2'd0);
  assign out_data  = r_q0;
  assign out_last  = r_l0 & out_valid;
  assign count     = r_count;
  assign busy      = r_busy;
  assign overflow  = r_overflow;

endmodule

// File: doc/kmean_replay_mem.md
# kmean_replay_mem

Parametrised sample store for the K-means datapath. It captures one burst of samples from the input stream into a single-port synchronous RAM, then replays the stored set in order as many times as the iteration controller requests. Each replay runs forward or reverse, with output back-pressure. It is the next generation of the two-word load/replay memory, generalised in width and depth, and adds on-demand replay, reverse mode, flow control and overflow reporting.

## Interface
- `DATA_W`, 16: sample width.
- `DEPTH`, 4096: sample capacity; power of two, ≥2.
- `AUTO_REPLAY`, 1: 1 = one forward replay starts automatically when a non-empty load ends; 0 = replay only on `rd_start`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  load strobe; a contiguous high run is one burst.
- `in_data`  in  DATA_W  sample, sampled when `in_valid`=1.
- `rd_start`  in  1  one-cycle request to replay the stored set.
- `rd_reverse`  in  1  sampled with `rd_start`: 1 = replay from last to first.
- `out_ready`  in  1  consumer ready.
- `out_valid`  out  1  `out_data` valid.
- `out_data`  out  DATA_W  replayed sample.
- `out_last`  out  1  high with the final word of a replay.
- `count`  out  $clog2(DEPTH)+1  number of stored samples.
- `busy`  out  1  high in LOAD or REPLAY.
- `overflow`  out  1  sticky: a word was dropped.

## Operation
- States: IDLE, LOAD, READY, REPLAY.
- From IDLE or READY, `in_valid`=1 does the following:
  - Enters LOAD.
  - Clears `count` and `overflow`.
  - Writes the word to address 0.
- In LOAD, each `in_valid` word is written at address `count`, then `count` increments.
  - When `count`==DEPTH, further words are dropped and `overflow` is set.
- In LOAD, the first cycle with `in_valid`=0 ends the load and the state goes to READY.
  - If AUTO_REPLAY=1 and `count`>0, the state goes to REPLAY in forward mode instead.
- READY with `rd_start`=1 goes to REPLAY. The direction is latched from `rd_reverse`.
  - If `count`==0, the state stays READY and no output is produced.
- REPLAY emits exactly `count` words.
  - Forward reads addresses 0..count-1.
  - Reverse reads addresses count-1..0.
  - `out_last` accompanies the final word.
  - After the handshake of the last word, the state goes to READY.
- A word transfers on `out_valid & out_ready`.
  - While `out_ready`=0, `out_data`, `out_valid` and `out_last` hold.
  - No word is skipped or duplicated.
- `rd_start` in LOAD or REPLAY is ignored.
- `in_valid` in REPLAY is ignored, and `overflow` is set.
- Stored contents persist across replays until the next load; any number of replays is allowed.
- If `rd_start` and `in_valid` are both high in READY, the load wins and `rd_start` is dropped.
- The address counter wraps only via explicit reload. Address arithmetic is $clog2(DEPTH) bits; `count` is one bit wider so it can hold DEPTH.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_last`=0.
  - `count`=0, `busy`=0, `overflow`=0.
  - State is IDLE.
  - RAM contents are not cleared.
- Reset mid-load or mid-replay aborts. All outputs are at reset values after the next edge.
- Write latency: a word sampled at edge t is readable from edge t+1.
- Replay start latency:
  - `rd_start` sampled at edge t gives `out_valid`=1 after edge t+2 (one state cycle plus one RAM read cycle).
  - AUTO_REPLAY: the first low `in_valid` sampled at edge t gives `out_valid`=1 after edge t+2.
- Throughput is one word per cycle while `out_ready`=1, with no bubbles inside a replay.
- `out_valid` drops the cycle after the last-word handshake.
- `busy` is registered and follows the state with no extra delay.

## Structure
- Shared package `kmean_mem_pkg` holds:
  - the state enum;
  - an address/count width helper function;
  - the default DATA_W and DEPTH constants.
- Sub-module `kmean_sram_sp`:
  - single-port RAM, DEPTH x DATA_W;
  - synchronous write, registered 1-cycle read;
  - no reset on the array.
- Top level holds:
  - the FSM;
  - the address and count counters;
  - a 2-entry output skid buffer that absorbs RAM read latency under `out_ready` stalls.

## Test plan
- AUTO_REPLAY=1, `out_ready`=1; load 1024, 512.
  - Expect out 1024 then 512, with `out_last` on 512.
  - `out_valid`=0 the following cycle; `count`=2.
- After the above, pulse `rd_start` with `rd_reverse`=1.
  - Expect 512 then 1024 two cycles later.
  - Pulse again with `rd_reverse`=0 and expect 1024, 512.
- Load 1..8; drop `out_ready` for 3 cycles while word 3 is presented.
  - Word 3 holds stable.
  - Full sequence 1..8 arrives exactly once, with `out_last` on 8.
- DEPTH=4; load 1..6.
  - Expect `count`=4 and `overflow`=1; replay gives 1,2,3,4.
  - A new load of 9 clears `overflow`, and the replay is 9.
- Assert `rst` during the 3rd word of an 8-word replay.
  - All outputs are 0 the next cycle and the state is IDLE.
  - `rd_start` before any new load gives no output.
- AUTO_REPLAY=0: `rd_start` with `count`=0 gives no output.
  - Load 7,7,7 and pulse `rd_start` during the replay; the extra request is ignored and exactly 3 words are emitted.
